// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the multiplexed hex display scanner.
//   - scan_state_e / ST_OFF / ST_SCAN : scanner FSM encoding
//   - BLANK_CODE                      : decoder code that turns a digit off
//   - NIBBLE_W                        : bits per displayed hex digit
//   - nibble_code()                   : builds a visible decoder code
// -----------------------------------------------------------------------------
package hex_display_pkg;

   localparam int NIBBLE_W = 4;

   // bit4 set tells the shared seven-segment decoder to blank the digit
   localparam logic [4:0] BLANK_CODE = 5'b10000;

   typedef enum logic [0:0] {
      OFF  = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   // Plain constants with the same encoding as scan_state_e, for state flops
   // kept as bare logic vectors.
   localparam logic [0:0] ST_OFF  = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   function automatic logic [4:0] nibble_code(input logic [NIBBLE_W-1:0] nib);
      return {1'b0, nib};
   endfunction

endpackage

// File: rtl/refresh_divider.sv
// -----------------------------------------------------------------------------
// refresh_divider
// Slot prescaler: counts 0..REFRESH_DIV-1 while run=1 and wraps; held at 0
// while run=0.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   run   : count enable; 0 clears the count
//   tick  : high in the cycle the count sits at its terminal value
// -----------------------------------------------------------------------------
module refresh_divider
   import hex_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run) begin
         cnt_d = '0;
      end else if (cnt_q == TERM) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign tick = run && (cnt_q == TERM);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared seven-segment
// decoder. Each digit is lit for REFRESH_DIV clocks. New display values are
// double-buffered so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   enable     : 1 = scan, 0 = display off
//   load       : value-valid strobe, taken only when ready=1
//   value      : 4*NUM_DIGITS bits, digit i = value[4i+3:4i]
//   ready      : 1 = a load is accepted this cycle
//   digit_code : to the decoder; bit4=1 blanks, bits3:0 = nibble
//   digit_en   : active-low one-hot digit select
//   frame_done : one-cycle pulse after the last digit slot of a frame
//   state_dbg  : current FSM state (0 = OFF, 1 = SCAN)
//
// Handshake: load/ready is valid/ready. A transfer happens on a rising edge
// where load=1 and ready=1; load with ready=0 is dropped, nothing changes.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero nibble (digit 0 is always shown).
// -----------------------------------------------------------------------------
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         load,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
   output logic                         ready,
   output logic [4:0]                   digit_code,
   output logic [NUM_DIGITS-1:0]        digit_en,
   output logic                         frame_done,
   output logic [0:0]                   state_dbg
);

   localparam int DATA_W = NIBBLE_W * NUM_DIGITS;
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [0:0]            state_q,      state_d;
   logic [IDX_W-1:0]      idx_q,        idx_d;
   logic [DATA_W-1:0]     shadow_q,     shadow_d;
   logic [DATA_W-1:0]     pend_q,       pend_d;
   logic                  pend_flag_q,  pend_flag_d;
   logic [NUM_DIGITS-1:0] digit_en_q,   digit_en_d;
   logic [4:0]            digit_code_q, digit_code_d;
   logic                  frame_done_q, frame_done_d;

   logic                  scan_active;
   logic                  leaving;
   logic                  run;
   logic                  tick;
   logic                  frame_end;
   logic                  load_ok;
   logic [NIBBLE_W-1:0]   cur_nibble;
   logic                  blank_digit;

   assign scan_active = (state_q == ST_SCAN);
   assign leaving     = scan_active && !enable;
   // Stop the prescaler in the exit cycle so it is already 0 in OFF and a
   // frame cut short by enable=0 never reports completion.
   assign run         = scan_active && enable;
   assign frame_end   = tick && (idx_q == LAST_IDX);
   assign ready       = !pend_flag_q;
   assign load_ok     = load && ready;

   refresh_divider #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh_divider (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .tick  (tick)
   );

   // Nibble of the digit currently being scanned.
   always_comb begin
      cur_nibble = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nibble = shadow_q[NIBBLE_W*i +: NIBBLE_W];
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [IDX_W-1:0] msd_idx;

   // Highest nonzero digit; stays 0 for an all-zero shadow so "0" is shown.
   always_comb begin
      msd_idx = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (shadow_q[NIBBLE_W*i +: NIBBLE_W] != '0) begin
            msd_idx = IDX_W'(i);
         end
      end
   end

   assign blank_digit = (idx_q > msd_idx);
`else
   assign blank_digit = 1'b0;
`endif

   // FSM and digit index.
   always_comb begin
      state_d = enable ? ST_SCAN : ST_OFF;
      idx_d   = idx_q;
      if (!run) begin
         idx_d = '0;
      end else if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Shadow / pending buffering.
   always_comb begin
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (!scan_active) begin
         // Nothing is being scanned, so a load can go straight to the display.
         if (load_ok) begin
            shadow_d = value;
         end
      end else if (leaving) begin
         // Entering OFF: flush any pending value; otherwise a load this cycle
         // is treated like an OFF load so ready stays 1 in OFF.
         if (pend_flag_q) begin
            shadow_d    = pend_q;
            pend_flag_d = 1'b0;
         end else if (load_ok) begin
            shadow_d = value;
         end
      end else begin
         // Copy decision uses the old flag, so a load taken in the frame-end
         // cycle waits for the following frame end.
         if (frame_end && pend_flag_q) begin
            shadow_d    = pend_q;
            pend_flag_d = 1'b0;
         end
         if (load_ok) begin
            pend_d      = value;
            pend_flag_d = 1'b1;
         end
      end
   end

   // Registered display outputs, lagging the digit index by one cycle.
   always_comb begin
      digit_en_d   = '1;
      digit_code_d = BLANK_CODE;
      if (run) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_en_d[i] = (idx_q != IDX_W'(i));
         end
         digit_code_d = blank_digit ? BLANK_CODE : nibble_code(cur_nibble);
      end
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_OFF;
         idx_q        <= '0;
         shadow_q     <= '0;
         pend_q       <= '0;
         pend_flag_q  <= 1'b0;
         digit_en_q   <= '1;
         digit_code_q <= BLANK_CODE;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         pend_flag_q  <= pend_flag_d;
         digit_en_q   <= digit_en_d;
         digit_code_q <= digit_code_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit_en   = digit_en_q;
   assign digit_code = digit_code_q;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

   localparam int ND = 4;
   localparam int RD = 4;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [4:0] HZ = 5'h10;  // leading zero digit
`else
   localparam logic [4:0] HZ = 5'h00;
`endif

   logic          clk;
   logic          reset;
   logic          enable;
   logic          load;
   logic [15:0]   value;
   logic          ready;
   logic [4:0]    digit_code;
   logic [3:0]    digit_en;
   logic          frame_done;
   logic [0:0]    state_dbg;

   hex_display_scanner #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .ready      (ready),
      .digit_code (digit_code),
      .digit_en   (digit_en),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         k;
      logic [3:0] en;
      logic [4:0] code;
      logic       fd;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   k      = 0;   // edges since enable was raised

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic add(input int kk, input logic [3:0] en, input logic [4:0] code,
                      input logic fd, input logic rdy);
      vecs.push_back('{kk, en, code, fd, rdy});
   endtask

   task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] en, input logic [4:0] code,
                            input logic fd, input logic rdy);
      check_bits({tag, " digit_en"},   32'(digit_en),   32'(en));
      check_bits({tag, " digit_code"}, 32'(digit_code), 32'(code));
      check_bits({tag, " frame_done"}, 32'(frame_done), 32'(fd));
      check_bits({tag, " ready"},      32'(ready),      32'(rdy));
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         while (k < vecs[i].k) step();
         check_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].code, vecs[i].fd, vecs[i].rdy);
      end
   endtask

   int seg_a, seg_b, seg_c, seg_d, seg_e, seg_f;

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      value  = '0;

      // shadow = 1234, steady scan
      add(0,  4'hF, 5'h10, 1'b0, 1'b1);
      add(1,  4'hE, 5'h04, 1'b0, 1'b1);
      add(4,  4'hE, 5'h04, 1'b0, 1'b1);
      add(5,  4'hD, 5'h03, 1'b0, 1'b1);
      add(9,  4'hB, 5'h02, 1'b0, 1'b1);
      add(13, 4'h7, 5'h01, 1'b0, 1'b1);
      add(15, 4'h7, 5'h01, 1'b0, 1'b1);
      add(16, 4'h7, 5'h01, 1'b1, 1'b1);
      add(17, 4'hE, 5'h04, 1'b0, 1'b1);
      seg_a = vecs.size();
      // ABCD pending mid-frame, 5555 ignored
      add(24, 4'hD, 5'h03, 1'b0, 1'b0);
      add(25, 4'hB, 5'h02, 1'b0, 1'b0);
      add(31, 4'h7, 5'h01, 1'b0, 1'b0);
      add(32, 4'h7, 5'h01, 1'b1, 1'b1);
      add(33, 4'hE, 5'h0D, 1'b0, 1'b1);
      add(37, 4'hD, 5'h0C, 1'b0, 1'b1);
      add(41, 4'hB, 5'h0B, 1'b0, 1'b1);
      add(45, 4'h7, 5'h0A, 1'b0, 1'b1);
      add(48, 4'h7, 5'h0A, 1'b1, 1'b1);
      add(49, 4'hE, 5'h0D, 1'b0, 1'b1);
      add(62, 4'h7, 5'h0A, 1'b0, 1'b1);
      seg_b = vecs.size();
      // 0050 loaded in the frame-end cycle
      add(64, 4'h7, 5'h0A, 1'b1, 1'b0);
      add(65, 4'hE, 5'h0D, 1'b0, 1'b0);
      add(79, 4'h7, 5'h0A, 1'b0, 1'b0);
      add(80, 4'h7, 5'h0A, 1'b1, 1'b1);
      add(81, 4'hE, 5'h00, 1'b0, 1'b1);
      add(85, 4'hD, 5'h05, 1'b0, 1'b1);
      add(89, 4'hB, HZ,    1'b0, 1'b1);
      add(93, 4'h7, HZ,    1'b0, 1'b1);
      add(96, 4'h7, HZ,    1'b1, 1'b1);
      seg_c = vecs.size();
      // shadow = 0000
      add(112, 4'h7, HZ,    1'b1, 1'b1);
      add(113, 4'hE, 5'h00, 1'b0, 1'b1);
      add(117, 4'hD, HZ,    1'b0, 1'b1);
      add(125, 4'h7, HZ,    1'b0, 1'b1);
      add(128, 4'h7, HZ,    1'b1, 1'b1);
      seg_d = vecs.size();
      // rescan after reset: shadow 0, pending 9999 discarded
      add(0,  4'hF, 5'h10, 1'b0, 1'b1);
      add(1,  4'hE, 5'h00, 1'b0, 1'b1);
      add(16, 4'h7, HZ,    1'b1, 1'b1);
      add(17, 4'hE, 5'h00, 1'b0, 1'b1);
      seg_e = vecs.size();
      // shadow 0042 flushed on enable drop
      add(1,  4'hE, 5'h02, 1'b0, 1'b1);
      add(5,  4'hD, 5'h04, 1'b0, 1'b1);
      add(9,  4'hB, HZ,    1'b0, 1'b1);
      add(13, 4'h7, HZ,    1'b0, 1'b1);
      add(16, 4'h7, HZ,    1'b1, 1'b1);
      seg_f = vecs.size();

      // reset
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_out("reset", 4'hF, 5'h10, 1'b0, 1'b1);
      check_bits("reset state", 32'(state_dbg), 32'd0);

      // load while OFF
      load = 1'b1; value = 16'h1234;
      step();
      load = 1'b0;
      check_out("off_load", 4'hF, 5'h10, 1'b0, 1'b1);

      enable = 1'b1; k = -1;
      step();
      run_vecs(0, seg_a);

      while (k < 20) step();
      load = 1'b1; value = 16'hABCD;
      step();
      load = 1'b0;
      check_bits("ready after mid-frame load", 32'(ready), 32'd0);
      step();
      load = 1'b1; value = 16'h5555;
      step();
      load = 1'b0;
      run_vecs(seg_a, seg_b);

      while (k < 63) step();
      load = 1'b1; value = 16'h0050;
      step();
      load = 1'b0;
      run_vecs(seg_b, seg_c);

      step();
      load = 1'b1; value = 16'h0000;
      step();
      load = 1'b0;
      check_bits("ready after zero load", 32'(ready), 32'd0);
      run_vecs(seg_c, seg_d);

      // reset during digit 2 with a load pending
      step();
      load = 1'b1; value = 16'h9999;
      step();
      load = 1'b0;
      check_bits("ready pending 9999", 32'(ready), 32'd0);
      while (k < 137) step();
      check_out("digit2 before reset", 4'hB, HZ, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      check_out("reset mid-frame", 4'hF, 5'h10, 1'b0, 1'b1);
      check_bits("reset mid-frame state", 32'(state_dbg), 32'd0);
      reset = 1'b0; enable = 1'b0;
      step();
      step();
      check_out("off after reset", 4'hF, 5'h10, 1'b0, 1'b1);

      enable = 1'b1; k = -1;
      step();
      run_vecs(seg_d, seg_e);

      // enable drop with pending set
      step();
      load = 1'b1; value = 16'h0042;
      step();
      load = 1'b0;
      check_bits("ready pending 0042", 32'(ready), 32'd0);
      step();
      enable = 1'b0;
      step();
      check_out("enable drop", 4'hF, 5'h10, 1'b0, 1'b1);
      check_bits("enable drop state", 32'(state_dbg), 32'd0);

      enable = 1'b1; k = -1;
      step();
      check_bits("re-enable state", 32'(state_dbg), 32'd1);
      run_vecs(seg_e, seg_f);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: 1 = scan display, 0 = display off.
REQ-006 SHALL have port load, input, 1 bit: value-valid strobe, accepted only when ready=1.
REQ-007 SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles, digit i = value[4i+3:4i].
REQ-008 SHALL have port ready, output, 1 bit: 1 = a load will be accepted this cycle.
REQ-009 SHALL have port digit_code, output, 5 bits: code to the shared seven-segment decoder; bit4=1 blanks, bits3:0 = hex nibble.
REQ-010 SHALL have port digit_en, output, NUM_DIGITS bits: active-low one-hot digit common select.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of the last digit slot.

Function
REQ-012 SHALL implement states OFF and SCAN; OFF->SCAN on the cycle after enable=1; SCAN->OFF on the cycle after enable=0.
REQ-013 In OFF: digit_en all ones, digit_code=5'h10, slot counter and digit index held at 0, frame_done=0.
REQ-014 In SCAN: slot counter counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and digit index increments, NUM_DIGITS-1 wrapping to 0.
REQ-015 digit_en and digit_code SHALL be registered and reflect the current digit index one cycle after the index changes, with exactly one digit_en bit low in SCAN.
REQ-016 Display data SHALL come from a shadow register only; value is never driven directly to digit_code.
REQ-017 In OFF: an accepted load writes value directly into the shadow register; ready stays 1.
REQ-018 In SCAN: an accepted load writes value into a pending register, sets the pending flag, and drives ready=0 from the next cycle.
REQ-019 At the end of the frame (terminal count of digit NUM_DIGITS-1), if the pending flag is set, pending SHALL copy to shadow and the flag clear; ready returns to 1 the next cycle (no mid-frame tearing).
REQ-020 load while ready=0 SHALL be ignored with no state change.
REQ-021 Load accepted in a frame-end cycle SHALL be transferred at the following frame end, not the current one.
REQ-022 frame_done SHALL pulse high for exactly one cycle per completed frame, coincident with the shadow update.
REQ-023 enable dropping with pending set SHALL copy pending to shadow on entry to OFF and clear the flag.

Reset
REQ-024 On reset=1 at a clock edge: state OFF, shadow=0, pending=0, pending flag=0, ready=1, counters=0, digit_en all ones, digit_code=5'h10, frame_done=0; reset overrides load and enable.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse and discard pending data.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: in SCAN, every digit above the most significant nonzero shadow nibble SHALL output digit_code=5'h10; digit 0 always shown, so shadow=0 displays a single "0".
REQ-027 Macro LEADING_ZERO_BLANK_EN undefined: all NUM_DIGITS digits SHALL show their nibble with bit4=0.

Structure
REQ-028 A shared package hex_display_pkg SHALL hold the state enum (OFF, SCAN), BLANK_CODE=5'b10000 and the digit-nibble width constant 4.
REQ-029 The slot prescaler SHALL be a sub-module refresh_divider (inputs clk, reset, run; output tick at terminal count).

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset, enable=0, load value=16'h1234 -> shadow=16'h1234, ready stays 1, digit_en=4'b1111, digit_code=5'h10.
REQ-031 enable=1 with shadow=16'h1234 -> digit_en cycles 1110,1101,1011,0111 with 4 cycles per slot; digit_code 04,03,02,01; frame_done pulses every 16 cycles.
REQ-032 Load 16'hABCD mid-frame -> ready=0 until frame end; the remainder of the current frame shows 1234; the next frame shows D,C,B,A; a second load while ready=0 is ignored.
REQ-033 LEADING_ZERO_BLANK_EN defined, shadow=16'h0050 -> codes 00,05,10,10; with shadow=16'h0000 -> 00,10,10,10; macro undefined -> 00,05,00,00.
REQ-034 reset pulsed during digit 2 with load pending -> next cycle all outputs at reset values, no frame_done pulse, pending data discarded.
REQ-035 load asserted in the frame-end cycle -> current frame_done occurs without a shadow change; the new value is displayed after the next frame_done.
